segre_sb_drain_arbiter: RTL and testbench

//  Owns the single data-cache port shared by pipeline loads and store-buffer (SB) drains.

---
 rtl/segre_pkg.sv | 22 ++
 rtl/segre_sb_drain_arbiter.sv | 177 +++++++++++++++++
 tb/tb_segre_sb_drain_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// ---------------------------------------------------------------------------
// segre_pkg
// Shared types and sizes for the store-buffer / data-cache port logic.
//   WORD_SIZE      width of addresses and data words on the cache port
//   SB_ENTRIES     capacity of the store buffer
//   SB_ENTRY_BITS  index width for SB_ENTRIES
//   sb_arb_state_t states of the cache-port arbiter
// ---------------------------------------------------------------------------
package segre_pkg;

    localparam int WORD_SIZE     = 32;
    localparam int SB_ENTRIES    = 4;
    localparam int SB_ENTRY_BITS = $clog2(SB_ENTRIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } sb_arb_state_t;

endpackage

// File: rtl/segre_sb_drain_arbiter.sv
// ---------------------------------------------------------------------------
// segre_sb_drain_arbiter
// Owns the single data-cache port shared by MEM-stage loads and store-buffer
// drains. Chooses the requester, holds the request stable until the cache
// accepts it, retires the SB head on an accepted drain, and runs a complete
// SB flush on a fence or when the SB is full.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   ld_req_i, ld_addr_i      load request (held until ld_gnt_o) and address
//   ld_gnt_o                 load accepted by the cache this cycle
//   fence_i                  pulse: drain the whole SB before continuing
//   sb_empty_i, sb_full_i    SB occupancy flags
//   sb_head_addr_i/data_i    oldest SB entry
//   sb_pop_o                 retire the SB head (accepted drain only)
//   dc_req_o, dc_we_o        cache request valid, 1 = write (drain)
//   dc_addr_o, dc_data_o     cache address / write data (data 0 on reads)
//   dc_ready_i               cache accepts the request this cycle
//   stall_o                  freeze the pipeline front-end
//   flush_done_o             one-cycle pulse when a flush completes
// ---------------------------------------------------------------------------
module segre_sb_drain_arbiter
    import segre_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int STARVE_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_req_i,
    input  logic [WORD_SIZE-1:0] ld_addr_i,
    output logic                 ld_gnt_o,
    input  logic                 fence_i,
    input  logic                 sb_empty_i,
    input  logic                 sb_full_i,
    input  logic [WORD_SIZE-1:0] sb_head_addr_i,
    input  logic [WORD_SIZE-1:0] sb_head_data_i,
    output logic                 sb_pop_o,
    output logic                 dc_req_o,
    output logic                 dc_we_o,
    output logic [WORD_SIZE-1:0] dc_addr_o,
    output logic [WORD_SIZE-1:0] dc_data_o,
    input  logic                 dc_ready_i,
    output logic                 stall_o,
    output logic                 flush_done_o
);

    sb_arb_state_t        state_q;
    logic [STARVE_W-1:0]  starve_cnt_q;
    logic                 dc_req_q;
    logic                 dc_we_q;
    logic [WORD_SIZE-1:0] dc_addr_q;
    logic [WORD_SIZE-1:0] dc_data_q;
    logic                 fence_pend_q;
    logic                 flush_done_q;

    logic                 accept;
    logic                 starved;
    logic [STARVE_W-1:0]  starve_inc;

    // Helper terms: an accept is a held request meeting dc_ready_i; the
    // starvation counter saturates at STARVE_MAX so it never wraps back to a
    // value that would let loads win again.
    always_comb begin
        accept     = dc_req_q & dc_ready_i;
        starved    = (starve_cnt_q >= STARVE_W'(STARVE_MAX));
        starve_inc = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
    end

    // Arbiter FSM. Every port signal is a register loaded when the decision is
    // made, so the request shows up one cycle later and cannot glitch while
    // the cache is deciding. A fence (or SB full) seen while a load or drain
    // is in flight is remembered in fence_pend_q and turns the completion
    // into a flush. In FLUSH a drain is issued only when no request is
    // pending, which gives the SB a cycle to present its new head after each
    // pop; the flush ends once the SB reports empty with nothing in flight.
    // A starved counter with an empty SB cannot force a drain, so loads are
    // still allowed through in that case instead of deadlocking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            dc_req_q     <= 1'b0;
            dc_we_q      <= 1'b0;
            dc_addr_q    <= '0;
            dc_data_q    <= '0;
            fence_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fence_i || sb_full_i) begin
                        fence_pend_q <= 1'b0;
                        if (sb_empty_i) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end else if (ld_req_i && (!starved || sb_empty_i)) begin
                        state_q   <= LOAD;
                        dc_req_q  <= 1'b1;
                        dc_we_q   <= 1'b0;
                        dc_addr_q <= ld_addr_i;
                        dc_data_q <= '0;
                    end else if (!sb_empty_i) begin
                        state_q   <= DRAIN;
                        dc_req_q  <= 1'b1;
                        dc_we_q   <= 1'b1;
                        dc_addr_q <= sb_head_addr_i;
                        dc_data_q <= sb_head_data_i;
                    end
                end
                LOAD, DRAIN: begin
                    if (fence_i || sb_full_i) begin
                        fence_pend_q <= 1'b1;
                    end
                    if (dc_ready_i) begin
                        dc_req_q     <= 1'b0;
                        dc_we_q      <= 1'b0;
                        dc_addr_q    <= '0;
                        dc_data_q    <= '0;
                        fence_pend_q <= 1'b0;
                        if (state_q == LOAD && !sb_empty_i) begin
                            starve_cnt_q <= starve_inc;
                        end else begin
                            starve_cnt_q <= '0;
                        end
                        if (fence_pend_q || fence_i || sb_full_i) begin
                            state_q <= FLUSH;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (dc_req_q) begin
                        if (dc_ready_i) begin
                            dc_req_q     <= 1'b0;
                            dc_we_q      <= 1'b0;
                            dc_addr_q    <= '0;
                            dc_data_q    <= '0;
                            starve_cnt_q <= '0;
                        end
                    end else if (!sb_empty_i) begin
                        dc_req_q  <= 1'b1;
                        dc_we_q   <= 1'b1;
                        dc_addr_q <= sb_head_addr_i;
                        dc_data_q <= sb_head_data_i;
                    end else begin
                        state_q      <= IDLE;
                        fence_pend_q <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output mapping. Grant and pop are the only same-cycle responses to
    // dc_ready_i; they are masked during reset so an abandoned drain never
    // retires its SB entry. SB full stalls the front-end in every state.
    always_comb begin
        dc_req_o     = dc_req_q;
        dc_we_o      = dc_we_q;
        dc_addr_o    = dc_addr_q;
        dc_data_o    = dc_data_q;
        ld_gnt_o     = accept & ~dc_we_q & ~rst_i;
        sb_pop_o     = accept & dc_we_q & ~rst_i;
        stall_o      = (state_q == FLUSH) | sb_full_i;
        flush_done_o = flush_done_q;
    end

endmodule

// File: tb/tb_segre_sb_drain_arbiter.sv
// ---------------------------------------------------------------------------
// tb_segre_sb_drain_arbiter
// Bench for segre_sb_drain_arbiter. A small store-buffer model and a load
// source feed the arbiter; a cache model answers requests after a chosen
// delay. Every store and load pushed is also queued as an expected cache
// transaction and compared when the arbiter's request is accepted.
// ---------------------------------------------------------------------------
module tb_segre_sb_drain_arbiter;
    import segre_pkg::*;

    typedef struct {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } sb_ent_t;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 ld_req_i = 1'b0;
    logic [WORD_SIZE-1:0] ld_addr_i = '0;
    logic                 ld_gnt_o;
    logic                 fence_i = 1'b0;
    logic                 sb_empty_i = 1'b1;
    logic                 sb_full_i = 1'b0;
    logic [WORD_SIZE-1:0] sb_head_addr_i = '0;
    logic [WORD_SIZE-1:0] sb_head_data_i = '0;
    logic                 sb_pop_o;
    logic                 dc_req_o;
    logic                 dc_we_o;
    logic [WORD_SIZE-1:0] dc_addr_o;
    logic [WORD_SIZE-1:0] dc_data_o;
    logic                 dc_ready_i = 1'b0;
    logic                 stall_o;
    logic                 flush_done_o;

    sb_ent_t              sb_q[$];
    sb_ent_t              exp_drain[$];
    logic [WORD_SIZE-1:0] ld_q[$];
    logic [WORD_SIZE-1:0] exp_ld[$];
    logic                 acc_seq[$];

    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_no = 0;
    int   ready_delay = 0;
    int   req_age = 0;
    logic force_ready = 1'b0;
    logic pop_pending = 1'b0;
    logic gnt_pending = 1'b0;
    logic acc = 1'b0;
    logic prev_req = 1'b0;
    logic prev_acc = 1'b0;
    logic prev_we = 1'b0;
    logic [WORD_SIZE-1:0] prev_addr = '0;
    logic [WORD_SIZE-1:0] prev_data = '0;
    logic s_req = 1'b0;
    logic s_we = 1'b0;
    logic s_flush_done = 1'b0;
    int   n_fd = 0;
    int   fd_tick = 0;
    int   gnt_tick = 0;
    int   n_req_cycles = 0;
    int   n_gnt = 0;
    int   n_drain_stall = 0;
    int   n_ld_stall = 0;

    segre_sb_drain_arbiter #(
        .STARVE_MAX(8),
        .STARVE_W  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ld_req_i      (ld_req_i),
        .ld_addr_i     (ld_addr_i),
        .ld_gnt_o      (ld_gnt_o),
        .fence_i       (fence_i),
        .sb_empty_i    (sb_empty_i),
        .sb_full_i     (sb_full_i),
        .sb_head_addr_i(sb_head_addr_i),
        .sb_head_data_i(sb_head_data_i),
        .sb_pop_o      (sb_pop_o),
        .dc_req_o      (dc_req_o),
        .dc_we_o       (dc_we_o),
        .dc_addr_o     (dc_addr_o),
        .dc_data_o     (dc_data_o),
        .dc_ready_i    (dc_ready_i),
        .stall_o       (stall_o),
        .flush_done_o  (flush_done_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    // Hard time limit so a wedged design still produces a verdict.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at tick %0d", tick_no);
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [WORD_SIZE-1:0] got,
                               input logic [WORD_SIZE-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, tick_no);
        end
    endtask

    // Drive the SB and load-source outputs from the model queues.
    task automatic refreshModels();
        ld_req_i       = (ld_q.size() != 0);
        ld_addr_i      = (ld_q.size() != 0) ? ld_q[0] : '0;
        sb_empty_i     = (sb_q.size() == 0);
        sb_full_i      = (sb_q.size() >= SB_ENTRIES);
        sb_head_addr_i = (sb_q.size() != 0) ? sb_q[0].addr : '0;
        sb_head_data_i = (sb_q.size() != 0) ? sb_q[0].data : '0;
    endtask

    task automatic pushStore(input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] d);
        sb_ent_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
        exp_drain.push_back(e);
        refreshModels();
    endtask

    task automatic pushLoad(input logic [WORD_SIZE-1:0] a);
        ld_q.push_back(a);
        exp_ld.push_back(a);
        refreshModels();
    endtask

    // One clock cycle: observe the DUT on the falling edge, score accepted
    // requests, then after the rising edge retire popped/granted entries and
    // update the cache-ready model.
    task automatic applyStimulus();
        sb_ent_t e;
        @(negedge clk_i);
        tick_no++;
        s_req        = dc_req_o;
        s_we         = dc_we_o;
        s_flush_done = flush_done_o;
        if (flush_done_o) begin
            n_fd++;
            fd_tick = tick_no;
        end
        if (dc_req_o) n_req_cycles++;
        acc = 1'b0;
        if (rst_i) begin
            checkOutput("rst_no_pop", sb_pop_o, 0);
            checkOutput("rst_no_gnt", ld_gnt_o, 0);
            prev_req = 1'b0;
        end else begin
            if (prev_req && !prev_acc) begin
                checkOutput("hold_req", dc_req_o, 1);
                checkOutput("hold_we", dc_we_o, prev_we);
                checkOutput("hold_addr", dc_addr_o, prev_addr);
                checkOutput("hold_data", dc_data_o, prev_data);
            end
            acc = dc_req_o && dc_ready_i;
            if (acc) begin
                acc_seq.push_back(dc_we_o);
                if (dc_we_o) begin
                    checkOutput("drain_queued", exp_drain.size() != 0, 1);
                    if (exp_drain.size() != 0) begin
                        e = exp_drain.pop_front();
                        checkOutput("drain_addr", dc_addr_o, e.addr);
                        checkOutput("drain_data", dc_data_o, e.data);
                    end
                    checkOutput("drain_pop", {sb_pop_o, ld_gnt_o}, 2'b10);
                    if (stall_o) n_drain_stall++;
                    pop_pending = 1'b1;
                end else begin
                    checkOutput("load_queued", exp_ld.size() != 0, 1);
                    if (exp_ld.size() != 0) begin
                        checkOutput("load_addr", dc_addr_o, exp_ld.pop_front());
                    end
                    checkOutput("load_data_zero", dc_data_o, 0);
                    checkOutput("load_gnt", {sb_pop_o, ld_gnt_o}, 2'b01);
                    if (stall_o) n_ld_stall++;
                    n_gnt++;
                    gnt_tick = tick_no;
                    gnt_pending = 1'b1;
                end
            end else begin
                checkOutput("no_spurious_pulse", {sb_pop_o, ld_gnt_o}, 0);
            end
            prev_req  = dc_req_o;
            prev_acc  = acc;
            prev_we   = dc_we_o;
            prev_addr = dc_addr_o;
            prev_data = dc_data_o;
        end
        @(posedge clk_i);
        #1;
        if (pop_pending && sb_q.size() != 0) void'(sb_q.pop_front());
        if (gnt_pending && ld_q.size() != 0) void'(ld_q.pop_front());
        pop_pending = 1'b0;
        gnt_pending = 1'b0;
        refreshModels();
        if (acc) req_age = 0;
        if (dc_req_o && !rst_i) begin
            dc_ready_i = force_ready | (req_age >= ready_delay);
            req_age++;
        end else begin
            req_age    = 0;
            dc_ready_i = force_ready;
        end
        #1;
    endtask

    // Run until every queued transaction has been accepted, then a few more
    // cycles so trailing flush_done pulses are observed.
    task automatic drainAll(input string tag, input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            applyStimulus();
            if (exp_ld.size() == 0 && exp_drain.size() == 0 && ld_q.size() == 0 &&
                sb_q.size() == 0 && !s_req) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput(tag, 0, 1);
        repeat (3) applyStimulus();
    endtask

    task automatic waitReq(input string tag, input logic we, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            applyStimulus();
            if (s_req && s_we == we) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(tag, 0, 1);
    endtask

    // Compare the recorded accept order (bit i = dc_we_o of accept i).
    task automatic checkSeq(input string tag, input int n, input logic [15:0] pattern);
        logic [1:0] got;
        checkOutput({tag, "_count"}, acc_seq.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < acc_seq.size()) ? {1'b0, acc_seq[i]} : 2'd2;
            checkOutput($sformatf("%s[%0d]", tag, i), got, {1'b0, pattern[i]});
        end
    endtask

    task automatic startScenario(input string name);
        $display("[TB] scenario: %s", name);
        acc_seq.delete();
        n_fd          = 0;
        n_req_cycles  = 0;
        n_gnt         = 0;
        n_drain_stall = 0;
        n_ld_stall    = 0;
    endtask

    initial begin
        // Power-on reset: all outputs quiet.
        startScenario("reset");
        rst_i = 1'b1;
        refreshModels();
        repeat (3) applyStimulus();
        checkOutput("rst_dc_req", dc_req_o, 0);
        checkOutput("rst_dc_we", dc_we_o, 0);
        checkOutput("rst_dc_addr", dc_addr_o, 0);
        checkOutput("rst_dc_data", dc_data_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_flush_done", flush_done_o, 0);
        rst_i = 1'b0;
        repeat (2) applyStimulus();

        // Reset in the middle of a drain abandons it without retiring the entry.
        startScenario("reset during drain");
        ready_delay = 20;
        pushStore(32'h200, 32'hDEAD_BEEF);
        waitReq("wait_drain_req", 1'b1, 10);
        rst_i       = 1'b1;
        force_ready = 1'b1;
        dc_ready_i  = 1'b1;
        applyStimulus();
        checkOutput("rst_mid_req_drop", dc_req_o, 0);
        checkOutput("rst_mid_we", dc_we_o, 0);
        applyStimulus();
        rst_i       = 1'b0;
        force_ready = 1'b0;
        dc_ready_i  = 1'b0;
        ready_delay = 0;
        checkOutput("rst_mid_no_retire", sb_q.size(), 1);
        drainAll("timeout_rst_drain", 40);
        checkSeq("rst_seq", 1, 16'h0001);

        // Single load with a slow cache: request held 3 cycles, one grant.
        startScenario("load only");
        ready_delay = 2;
        pushLoad(32'h100);
        drainAll("timeout_load", 40);
        checkOutput("load_req_cycles", n_req_cycles, 3);
        checkOutput("load_gnt_count", n_gnt, 1);
        checkSeq("load_seq", 1, 16'h0000);

        // Starvation: eight loads win, then a drain is forced, counter restarts.
        startScenario("starvation");
        ready_delay = 0;
        pushStore(32'h300, 32'h1111_0000);
        pushStore(32'h304, 32'h2222_0000);
        for (int i = 0; i < 10; i++) pushLoad(32'h1000 + 32'(i * 4));
        drainAll("timeout_starve", 200);
        checkSeq("starve_seq", 12, 16'h0900);

        // SB full: stall, four back-to-back drains, flush_done, then the load.
        startScenario("full flush");
        for (int i = 0; i < SB_ENTRIES; i++) pushStore(32'h400 + 32'(i * 4), 32'hA000 + 32'(i));
        pushLoad(32'h2000);
        drainAll("timeout_full", 200);
        checkSeq("full_seq", 5, 16'h000F);
        checkOutput("full_flush_done_count", n_fd, 1);
        checkOutput("full_drains_stalled", n_drain_stall, 4);
        checkOutput("full_load_after_flush", gnt_tick > fd_tick, 1);
        checkOutput("full_load_not_in_stall", n_ld_stall, 0);

        // Fence during a load: load completes, then a flush of two entries.
        startScenario("fence during load");
        ready_delay = 3;
        pushStore(32'h500, 32'h5555_0001);
        pushStore(32'h504, 32'h5555_0002);
        pushLoad(32'h3000);
        waitReq("wait_load_req", 1'b0, 10);
        fence_i = 1'b1;
        applyStimulus();
        fence_i = 1'b0;
        drainAll("timeout_fence_load", 200);
        checkSeq("fence_seq", 3, 16'h0006);
        checkOutput("fence_flush_done_count", n_fd, 1);
        checkOutput("fence_drains_stalled", n_drain_stall, 2);

        // Fence with an empty SB: no cache traffic, flush_done one cycle later.
        startScenario("fence empty");
        ready_delay = 0;
        fence_i = 1'b1;
        applyStimulus();
        checkOutput("fence_empty_fd_t0", s_flush_done, 0);
        fence_i = 1'b0;
        applyStimulus();
        checkOutput("fence_empty_fd_t1", s_flush_done, 1);
        applyStimulus();
        checkOutput("fence_empty_fd_t2", s_flush_done, 0);
        checkOutput("fence_empty_no_req", n_req_cycles, 0);
        checkOutput("fence_empty_no_stall", stall_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
